brc_serial_ctrl: RTL

BRC_SERIAL_CTRL -- requirements
Module: brc_serial_ctrl

---
 rtl/brc_pkg.sv | 47 ++++
 rtl/brc_serial_ctrl_comp8.sv | 22 ++
 rtl/brc_serial_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/brc_pkg.sv
// ============================================================================
// Module : brc_pkg
// Shared branch-compare constants, FSM state type and condition helpers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package brc_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b010) || (f3 == 3'b011);
    endfunction

    function automatic logic f3_signed(input logic [2:0] f3);
        return (f3 == BLT) || (f3 == BGE);
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic       lt,
                                          input logic       eq);
        logic t;
        case (f3)
            BEQ:         t = eq;
            BNE:         t = !eq;
            BLT, BLTU:   t = lt;
            BGE, BGEU:   t = !lt;
            default:     t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

`default_nettype wire

// File: rtl/brc_serial_ctrl_comp8.sv
// ============================================================================
// Module : Comp8_8
// 8-bit cascadable magnitude slice: results qualified by equality of the
// more-significant bytes (equ_in).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module Comp8_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       equ_in,
    output logic       less,
    output logic       equal
);

    assign less  = equ_in && (a < b);
    assign equal = equ_in && (a == b);

endmodule

`default_nettype wire

// File: rtl/brc_serial_ctrl.sv
// ============================================================================
// Module : brc_serial_ctrl
// Byte-serial branch comparator: one shared 8-bit slice walks MSB to LSB.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module brc_serial_ctrl
    import brc_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [2:0]  funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        taken,
    output logic        less,
    output logic        equal,
    output logic        illegal
);

    state_t      r_state;
    logic [1:0]  r_idx;
    logic        r_eq_acc;
    logic        r_less_acc;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic [2:0]  r_funct3;
    logic        r_taken;
    logic        r_less;
    logic        r_equal;
    logic        r_illegal;

    logic [7:0]  w_byte_a;
    logic [7:0]  w_byte_b;
    logic        w_slice_less;
    logic        w_slice_eq;
    logic        w_less_final;
    logic        w_last;
    logic [31:0] w_sign_flip;

    assign w_byte_a     = r_op_a[{r_idx, 3'b000} +: 8];
    assign w_byte_b     = r_op_b[{r_idx, 3'b000} +: 8];
    assign w_less_final = r_less_acc | w_slice_less;
    assign w_last       = (r_idx == 2'd0) || (EARLY_EXIT && !w_slice_eq);
    // Biasing the sign bit turns two's-complement order into unsigned order.
    assign w_sign_flip  = {f3_signed(funct3), 31'd0};

    Comp8_8 u_comp (
        .a      (w_byte_a),
        .b      (w_byte_b),
        .equ_in (r_eq_acc),
        .less   (w_slice_less),
        .equal  (w_slice_eq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= 2'd3;
            r_eq_acc   <= 1'b1;
            r_less_acc <= 1'b0;
            r_op_a     <= 32'd0;
            r_op_b     <= 32'd0;
            r_funct3   <= 3'd0;
            r_taken    <= 1'b0;
            r_less     <= 1'b0;
            r_equal    <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op_a     <= rs1 ^ w_sign_flip;
                        r_op_b     <= rs2 ^ w_sign_flip;
                        r_funct3   <= funct3;
                        r_idx      <= 2'd3;
                        r_eq_acc   <= 1'b1;
                        r_less_acc <= 1'b0;
                        r_state    <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (f3_illegal(r_funct3)) begin
                        r_illegal <= 1'b1;
                        r_taken   <= 1'b0;
                        r_less    <= 1'b0;
                        r_equal   <= 1'b0;
                        r_state   <= S_DONE;
                    end else begin
                        r_eq_acc   <= w_slice_eq;
                        r_less_acc <= w_less_final;
                        if (w_last) begin
                            r_illegal <= 1'b0;
                            r_less    <= w_less_final;
                            r_equal   <= w_slice_eq;
                            r_taken   <= branch_taken(r_funct3, w_less_final, w_slice_eq);
                            r_state   <= S_DONE;
                        end else begin
                            r_idx <= r_idx - 2'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        r_taken   <= 1'b0;
                        r_less    <= 1'b0;
                        r_equal   <= 1'b0;
                        r_illegal <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_DONE);
    assign taken     = r_taken;
    assign less      = r_less;
    assign equal     = r_equal;
    assign illegal   = r_illegal;

endmodule

`default_nettype wire
